regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32x32 register file. Shares the file's single write port between the in-order pipeline write-back stage and a long-latency unit (LLU, e.g. mul/div or miss-load) that returns results out of order. Tracks in-flight LLU destinations so decode can stall on RAW/WAW hazards. Guarantees LLU forward progress by briefly freezing the pipeline. Sits between the WB stage, the LLU result port and the register file write inputs.

---
 rtl/regfile_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between pipeline WB and the long-latency unit, with an in-flight scoreboard.
// Define WB_STARVE_GUARD_EN to enable the forced LLU grant (pipeline freeze) after STARVE_LIMIT denials.
//
// state   | meaning
// IDLE    | no LLU result waiting behind a pipeline write
// WAIT    | LLU result denied at least once, counting down to a forced grant
// FORCE   | pipeline frozen, LLU owns the write port this cycle
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iPipeWriteEn,
    input  logic [ADDRESS_WIDTH-1:0] iPipeRd,
    input  logic [DATA_WIDTH-1:0]    iPipeData,
    input  logic                     iLluValid,
    input  logic [ADDRESS_WIDTH-1:0] iLluRd,
    input  logic [DATA_WIDTH-1:0]    iLluData,
    output logic                     oLluReady,
    input  logic                     iIssueValid,
    input  logic [ADDRESS_WIDTH-1:0] iIssueRd,
    input  logic [ADDRESS_WIDTH-1:0] iRs1,
    input  logic [ADDRESS_WIDTH-1:0] iRs2,
    input  logic [ADDRESS_WIDTH-1:0] iRdDec,
    output logic                     oHazard,
    output logic                     oStallPipe,
    output logic                     oWriteEn,
    output logic [ADDRESS_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0]    oDataIn
);

    localparam int NUM_REGS = 1 << ADDRESS_WIDTH;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    starve_cnt, starve_cnt_next;
    logic [NUM_REGS-1:0] pending, pending_next, pending_eff;
    logic                llu_grant;
    logic                pipe_sel;
    logic [ADDRESS_WIDTH-1:0] sel_rd;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            pending    <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
            pending    <= pending_next;
        end
    end

    // starve_cnt holds the denials still allowed before the grant is forced
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (iLluValid && iPipeWriteEn) begin
`ifdef WB_STARVE_GUARD_EN
                    if (STARVE_LIMIT == 1) begin
                        state_next      = ST_FORCE;
                        starve_cnt_next = '0;
                    end else begin
                        state_next      = ST_WAIT;
                        starve_cnt_next = CNT_W'(STARVE_LIMIT - 1);
                    end
`else
                    state_next      = ST_WAIT;
                    starve_cnt_next = CNT_W'(STARVE_LIMIT - 1);
`endif
                end
            end
            ST_WAIT: begin
                if (!iLluValid || !iPipeWriteEn) begin
                    state_next      = ST_IDLE;
                    starve_cnt_next = '0;
                end else begin
`ifdef WB_STARVE_GUARD_EN
                    if (starve_cnt == CNT_W'(1)) begin
                        state_next      = ST_FORCE;
                        starve_cnt_next = '0;
                    end else begin
                        starve_cnt_next = starve_cnt - CNT_W'(1);
                    end
`else
                    if (starve_cnt != '0)
                        starve_cnt_next = starve_cnt - CNT_W'(1);
`endif
                end
            end
            ST_FORCE: begin
                state_next      = ST_IDLE;
                starve_cnt_next = '0;
            end
            default: begin
                state_next      = ST_IDLE;
                starve_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
`ifdef WB_STARVE_GUARD_EN
        oStallPipe = !iRst && (state == ST_FORCE);
`else
        oStallPipe = 1'b0;
`endif
        llu_grant     = !iRst && iLluValid && (!iPipeWriteEn || oStallPipe);
        pipe_sel      = !iRst && iPipeWriteEn && !oStallPipe;
        sel_rd        = llu_grant ? iLluRd : iPipeRd;
        oLluReady     = llu_grant;
        oWriteEn      = (llu_grant || pipe_sel) && (sel_rd != '0);
        oWriteAddress = iRst ? '0 : sel_rd;
        oDataIn       = iRst ? '0 : (llu_grant ? iLluData : iPipeData);

        // the register file forwards the LLU write, so its bit no longer blocks decode
        pending_eff = pending;
        if (llu_grant)
            pending_eff[iLluRd] = 1'b0;
        oHazard = !iRst && (pending_eff[iRs1] || pending_eff[iRs2] || pending_eff[iRdDec]);
    end

    always_comb begin
        pending_next = pending;
        if (llu_grant)
            pending_next[iLluRd] = 1'b0;
        if (iIssueValid && (iIssueRd != '0))
            pending_next[iIssueRd] = 1'b1;
        pending_next[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; expectations follow WB_STARVE_GUARD_EN the same way as the design.
module tb_regfile_wb_arbiter;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iPipeWriteEn = 1'b0;
    logic [4:0]  iPipeRd = '0;
    logic [31:0] iPipeData = '0;
    logic        iLluValid = 1'b0;
    logic [4:0]  iLluRd = '0;
    logic [31:0] iLluData = '0;
    logic        oLluReady;
    logic        iIssueValid = 1'b0;
    logic [4:0]  iIssueRd = '0;
    logic [4:0]  iRs1 = '0;
    logic [4:0]  iRs2 = '0;
    logic [4:0]  iRdDec = '0;
    logic        oHazard;
    logic        oStallPipe;
    logic        oWriteEn;
    logic [4:0]  oWriteAddress;
    logic [31:0] oDataIn;

    always #5 iClk = ~iClk;

    regfile_wb_arbiter #(
        .ADDRESS_WIDTH(5),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(4)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iPipeWriteEn(iPipeWriteEn),
        .iPipeRd(iPipeRd),
        .iPipeData(iPipeData),
        .iLluValid(iLluValid),
        .iLluRd(iLluRd),
        .iLluData(iLluData),
        .oLluReady(oLluReady),
        .iIssueValid(iIssueValid),
        .iIssueRd(iIssueRd),
        .iRs1(iRs1),
        .iRs2(iRs2),
        .iRdDec(iRdDec),
        .oHazard(oHazard),
        .oStallPipe(oStallPipe),
        .oWriteEn(oWriteEn),
        .oWriteAddress(oWriteAddress),
        .oDataIn(oDataIn)
    );

    typedef struct {
        logic        rst;
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rdd;
        logic [40:0] exp;
    } cyc_t;

    int total = 0;
    int bad = 0;
    logic [40:0] exp_q[$];

    // expected vector layout: {we, addr[4:0], data[31:0], llu_ready, hazard, stall}
    function automatic logic [40:0] ex(input logic we, input logic [4:0] a, input logic [31:0] d,
                                       input logic rdy, input logic hz, input logic st);
        return {we, a, d, rdy, hz, st};
    endfunction

    function automatic cyc_t mk(input logic rst, input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                input logic iv, input logic [4:0] ird,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdd,
                                input logic [40:0] e);
        cyc_t c;
        c.rst = rst; c.pwe = pwe; c.prd = prd; c.pdat = pdat;
        c.lv = lv; c.lrd = lrd; c.ldat = ldat;
        c.iv = iv; c.ird = ird;
        c.rs1 = rs1; c.rs2 = rs2; c.rdd = rdd;
        c.exp = e;
        return c;
    endfunction

    function automatic logic [40:0] obs();
        return {oWriteEn, oWriteAddress, oDataIn, oLluReady, oHazard, oStallPipe};
    endfunction

    task automatic drive(input cyc_t c);
        @(posedge iClk);
        #1;
        iRst = c.rst;
        iPipeWriteEn = c.pwe; iPipeRd = c.prd; iPipeData = c.pdat;
        iLluValid = c.lv; iLluRd = c.lrd; iLluData = c.ldat;
        iIssueValid = c.iv; iIssueRd = c.ird;
        iRs1 = c.rs1; iRs2 = c.rs2; iRdDec = c.rdd;
    endtask

    task automatic test_reset();
        cyc_t seq[$];
        for (int i = 0; i < 3; i++)
            seq.push_back(mk(1'b1, 1'b1, 5'd3, 32'hAAAA_0000, 1'b1, 5'd7, 32'h5555_0000, 1'b1, 5'd5,
                             5'd5, 5'd7, 5'd9, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        for (int i = 0; i < 32; i++)
            seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0,
                             5'(i), 5'((i + 7) % 32), 5'(31 - i), ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        foreach (seq[k]) begin
            logic [40:0] e, got;
            drive(seq[k]);
            exp_q.push_back(seq[k].exp);
            @(negedge iClk);
            got = obs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset[%0d] got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_issue_hazard();
        cyc_t seq[$];
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5, 5'd5, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd5, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, '0, 5'd5, '0, ex(1'b0, '0, '0, 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, 5'd5, '0, '0,
                         ex(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd5, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd12, '0, ex(1'b0, '0, '0, 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 5'd12, ex(1'b0, '0, '0, 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd13, 5'd11, 5'd4, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, 5'd12, 32'h1212_1212, 1'b0, '0, 5'd12, 5'd5, '0,
                         ex(1'b1, 5'd12, 32'h1212_1212, 1'b1, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 5'd12, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        foreach (seq[k]) begin
            logic [40:0] e, got;
            drive(seq[k]);
            exp_q.push_back(seq[k].exp);
            @(negedge iClk);
            got = obs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL issue_hazard[%0d] got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_pipe_priority();
        cyc_t seq[$];
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b0, '0, 5'd7, '0, '0,
                         ex(1'b1, 5'd3, 32'h33, 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h77, 1'b0, '0, 5'd7, '0, '0,
                         ex(1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd7, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b1, 5'd0, 32'h99, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, ex(1'b0, 5'd0, 32'h99, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88, 1'b0, '0, '0, '0, '0,
                         ex(1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b1, 5'd4, 32'h45, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0,
                         ex(1'b1, 5'd4, 32'h45, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        foreach (seq[k]) begin
            logic [40:0] e, got;
            drive(seq[k]);
            exp_q.push_back(seq[k].exp);
            @(negedge iClk);
            got = obs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL pipe_priority[%0d] got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_starve();
        cyc_t seq[$];
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd10, '0, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
`ifdef WB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++)
            seq.push_back(mk(1'b0, 1'b1, 5'(1 + i), 32'(256 + i), 1'b1, 5'd10, 32'hA0A0_A0A0, 1'b0, '0, 5'd10, '0, '0,
                             ex(1'b1, 5'(1 + i), 32'(256 + i), 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b1, 5'd5, 32'h105, 1'b1, 5'd10, 32'hA0A0_A0A0, 1'b0, '0, 5'd10, '0, '0,
                         ex(1'b1, 5'd10, 32'hA0A0_A0A0, 1'b1, 1'b0, 1'b1)));
        seq.push_back(mk(1'b0, 1'b1, 5'd5, 32'h105, 1'b0, '0, '0, 1'b0, '0, 5'd10, '0, '0,
                         ex(1'b1, 5'd5, 32'h105, 1'b0, 1'b0, 1'b0)));
`else
        for (int i = 0; i < 6; i++)
            seq.push_back(mk(1'b0, 1'b1, 5'(1 + i), 32'(256 + i), 1'b1, 5'd10, 32'hA0A0_A0A0, 1'b0, '0, 5'd10, '0, '0,
                             ex(1'b1, 5'(1 + i), 32'(256 + i), 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, 5'd10, 32'hA0A0_A0A0, 1'b0, '0, 5'd10, '0, '0,
                         ex(1'b1, 5'd10, 32'hA0A0_A0A0, 1'b1, 1'b0, 1'b0)));
`endif
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd10, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        foreach (seq[k]) begin
            logic [40:0] e, got;
            drive(seq[k]);
            exp_q.push_back(seq[k].exp);
            @(negedge iClk);
            got = obs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL starve[%0d] got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_x0();
        cyc_t seq[$];
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, '0, '0, '0, '0,
                         ex(1'b0, 5'd0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0, '0, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        foreach (seq[k]) begin
            logic [40:0] e, got;
            drive(seq[k]);
            exp_q.push_back(seq[k].exp);
            @(negedge iClk);
            got = obs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL x0[%0d] got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_same_cycle();
        cyc_t seq[$];
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, '0, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd9, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h9999_9999, 1'b1, 5'd9, 5'd9, '0, '0,
                         ex(1'b1, 5'd9, 32'h9999_9999, 1'b1, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd9, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h9, 1'b0, '0, 5'd9, '0, '0, ex(1'b1, 5'd9, 32'h9, 1'b1, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd9, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        foreach (seq[k]) begin
            logic [40:0] e, got;
            drive(seq[k]);
            exp_q.push_back(seq[k].exp);
            @(negedge iClk);
            got = obs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL same_cycle[%0d] got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_force();
        cyc_t seq[$];
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd6, '0, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        for (int i = 0; i < 4; i++)
            seq.push_back(mk(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66, 1'b0, '0, 5'd6, '0, '0,
                             ex(1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b0)));
        seq.push_back(mk(1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66, 1'b0, '0, 5'd6, '0, '0,
                         ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd6, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66, 1'b0, '0, 5'd6, '0, '0,
                         ex(1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b0)));
        seq.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
        foreach (seq[k]) begin
            logic [40:0] e, got;
            drive(seq[k]);
            exp_q.push_back(seq[k].exp);
            @(negedge iClk);
            got = obs();
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_mid_force[%0d] got=%h expected=%h", k, got, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout waiting for the sequence to finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_issue_hazard();
        test_pipe_priority();
        test_starve();
        test_x0();
        test_same_cycle();
        test_reset_mid_force();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
